// File: rtl/udp_rx_pkg.sv
// Shared definitions for the GMII/UDP command receive path: parser state
// encoding, protocol header sizes, field constants and CRC-32 parameters.
package udp_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        ETH_HDR,
        IP_HDR,
        UDP_HDR,
        PAYLOAD,
        TAIL,
        DROP
    } state_t;

    // Header sizes in bytes, sized to match the 11-bit byte counter.
    localparam logic [10:0] ETH_HDR_LEN  = 11'd14;
    localparam logic [10:0] IP_HDR_LEN   = 11'd20;
    localparam logic [10:0] UDP_HDR_LEN  = 11'd8;

    // Up to seven 0x55 bytes precede the SFD; the first one is seen in IDLE.
    localparam logic [10:0] MAX_EXTRA_PREAMBLE = 11'd6;
    localparam logic [7:0]  PREAMBLE_BYTE      = 8'h55;
    localparam logic [7:0]  SFD_BYTE           = 8'hD5;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IP_VER_IHL     = 8'h45;
    localparam logic [7:0]  IP_PROTO_UDP   = 8'h11;

    localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

    // Byte idx (0 = most significant, as sent on the wire) of a 48-bit field.
    function automatic logic [7:0] wire_byte48(input logic [47:0] v, input logic [2:0] idx);
        logic [47:0] sh;
        if (idx > 3'd5) begin
            return 8'h00;
        end
        sh = v >> ((5 - int'(idx)) * 8);
        return sh[7:0];
    endfunction

    // Byte idx (0 = most significant, as sent on the wire) of a 32-bit field.
    function automatic logic [7:0] wire_byte32(input logic [31:0] v, input logic [1:0] idx);
        logic [31:0] sh;
        sh = v >> ((3 - int'(idx)) * 8);
        return sh[7:0];
    endfunction

endpackage

// File: rtl/udp_cmd_rx_if.sv
// Payload stream and frame status from the UDP command parser to the
// control logic. The parser drives through master, the consumer reads slave.
interface udp_cmd_rx_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic [15:0] payload_len;
    logic        frame_ok;
    logic        frame_err;
    logic [15:0] pkt_count;

    modport master (
        output rx_data, rx_valid, rx_sof, rx_eof,
        output payload_len, frame_ok, frame_err, pkt_count
    );

    modport slave (
        input rx_data, rx_valid, rx_sof, rx_eof,
        input payload_len, frame_ok, frame_err, pkt_count
    );
endinterface

// File: rtl/udp_cmd_rx_crc32_d8.sv
// Combinational Ethernet CRC-32 step for one byte, LSB-first (reflected).
// The caller owns the CRC register and its init/enable.
module crc32_d8
    import udp_rx_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    // Shift the byte through the reflected polynomial one bit at a time.
    always_comb begin
        crc_out = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC_POLY) : (crc_out >> 1);
        end
    end

endmodule

// File: rtl/udp_cmd_rx.sv
// GMII receive parser: finds preamble/SFD, filters on MAC, IPv4, UDP port
// and length, streams the UDP payload, and reports FCS status per frame.
module udp_cmd_rx
    import udp_rx_pkg::*;
#(
    parameter logic [47:0] LOCAL_MAC   = 48'h00_0A_35_01_FE_C0,
    parameter logic [31:0] LOCAL_IP    = 32'hC0A8_0002,
    parameter logic [15:0] LOCAL_PORT  = 16'd8080,
    parameter logic [15:0] MAX_PAYLOAD = 16'd1472
)(
    input  logic         e_rxc,
    input  logic         rst,
    input  logic         e_rxdv,
    input  logic         e_rxer,
    input  logic [7:0]   e_rxd,
    udp_cmd_rx_if.master rx
);

    // Registered GMII inputs
    logic        rxdv_reg;
    logic        rxer_reg;
    logic [7:0]  rxd_reg;

    // Parser state
    state_t      state_reg;
    logic [10:0] cnt_reg;
    logic [31:0] crc_reg;
    logic [31:0] crc_next;
    logic        mac_local_ok_reg;
    logic        mac_bcast_ok_reg;
    logic        type_hi_ok_reg;
    logic        err_reg;
    logic [15:0] port_reg;
    logic [15:0] len_reg;

    // Registered outputs
    logic [7:0]  rx_data_reg;
    logic        rx_valid_reg;
    logic        rx_sof_reg;
    logic        rx_eof_reg;
    logic [15:0] payload_len_reg;
    logic        frame_ok_reg;
    logic        frame_err_reg;
    logic [15:0] pkt_count_reg;

    // Per-byte decode helpers
    logic        ip_byte_bad;
    logic        udp_len_ok;
    logic        pay_last;

    crc32_d8 u_crc (
        .crc_in  (crc_reg),
        .data    (rxd_reg),
        .crc_out (crc_next)
    );

    // Register the GMII inputs once at the pins.
    always_ff @(posedge e_rxc) begin
        if (rst) begin
            rxdv_reg <= 1'b0;
            rxer_reg <= 1'b0;
            rxd_reg  <= 8'h00;
        end else begin
            rxdv_reg <= e_rxdv;
            rxer_reg <= e_rxer;
            rxd_reg  <= e_rxd;
        end
    end

    // Field checks for the byte currently in rxd_reg.
    always_comb begin
        ip_byte_bad = 1'b0;
        if (cnt_reg == 11'd0 && rxd_reg != IP_VER_IHL) begin
            ip_byte_bad = 1'b1;
        end
        if (cnt_reg == 11'd9 && rxd_reg != IP_PROTO_UDP) begin
            ip_byte_bad = 1'b1;
        end
        if (cnt_reg >= 11'd16 && rxd_reg != wire_byte32(LOCAL_IP, cnt_reg[1:0])) begin
            ip_byte_bad = 1'b1;
        end
        udp_len_ok = (len_reg >= 16'd8) && ((len_reg - 16'd8) <= MAX_PAYLOAD);
        pay_last   = ({5'd0, cnt_reg} == (payload_len_reg - 16'd1));
    end

    // Frame parser: state, byte counter, CRC and all registered outputs.
    always_ff @(posedge e_rxc) begin
        if (rst) begin
            state_reg        <= IDLE;
            cnt_reg          <= 11'd0;
            crc_reg          <= CRC_INIT;
            mac_local_ok_reg <= 1'b0;
            mac_bcast_ok_reg <= 1'b0;
            type_hi_ok_reg   <= 1'b0;
            err_reg          <= 1'b0;
            port_reg         <= 16'h0000;
            len_reg          <= 16'h0000;
            rx_data_reg      <= 8'h00;
            rx_valid_reg     <= 1'b0;
            rx_sof_reg       <= 1'b0;
            rx_eof_reg       <= 1'b0;
            payload_len_reg  <= 16'h0000;
            frame_ok_reg     <= 1'b0;
            frame_err_reg    <= 1'b0;
            pkt_count_reg    <= 16'h0000;
        end else begin
            rx_valid_reg  <= 1'b0;
            rx_sof_reg    <= 1'b0;
            rx_eof_reg    <= 1'b0;
            frame_ok_reg  <= 1'b0;
            frame_err_reg <= 1'b0;

            // Every byte after the SFD, FCS included, feeds the CRC and the
            // receive-error latch.
            if (rxdv_reg && (state_reg inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, TAIL})) begin
                crc_reg <= crc_next;
                if (rxer_reg) begin
                    err_reg <= 1'b1;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (rxdv_reg) begin
                        cnt_reg <= 11'd0;
                        // A frame that does not open with preamble is waited out.
                        state_reg <= (rxd_reg == PREAMBLE_BYTE) ? PREAMBLE : DROP;
                    end
                end

                PREAMBLE: begin
                    if (!rxdv_reg) begin
                        state_reg <= IDLE;
                    end else if (rxd_reg == SFD_BYTE) begin
                        state_reg        <= ETH_HDR;
                        cnt_reg          <= 11'd0;
                        crc_reg          <= CRC_INIT;
                        err_reg          <= 1'b0;
                        mac_local_ok_reg <= 1'b1;
                        mac_bcast_ok_reg <= 1'b1;
                        type_hi_ok_reg   <= 1'b0;
                    end else if (rxd_reg == PREAMBLE_BYTE && cnt_reg < MAX_EXTRA_PREAMBLE) begin
                        cnt_reg <= cnt_reg + 11'd1;
                    end else begin
                        state_reg <= DROP;
                        cnt_reg   <= 11'd0;
                    end
                end

                ETH_HDR: begin
                    if (!rxdv_reg) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 11'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 11'd1;
                        if (cnt_reg < 11'd6) begin
                            if (rxd_reg != wire_byte48(LOCAL_MAC, cnt_reg[2:0])) begin
                                mac_local_ok_reg <= 1'b0;
                            end
                            if (rxd_reg != 8'hFF) begin
                                mac_bcast_ok_reg <= 1'b0;
                            end
                        end
                        if (cnt_reg == 11'd12 && rxd_reg == ETHERTYPE_IPV4[15:8]) begin
                            type_hi_ok_reg <= 1'b1;
                        end
                        // Address and ethertype are judged together on the last byte.
                        if (cnt_reg == ETH_HDR_LEN - 11'd1) begin
                            cnt_reg <= 11'd0;
                            if ((mac_local_ok_reg || mac_bcast_ok_reg) && type_hi_ok_reg &&
                                rxd_reg == ETHERTYPE_IPV4[7:0]) begin
                                state_reg <= IP_HDR;
                            end else begin
                                state_reg <= DROP;
                            end
                        end
                    end
                end

                IP_HDR: begin
                    if (!rxdv_reg) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 11'd0;
                    end else if (ip_byte_bad) begin
                        state_reg <= DROP;
                        cnt_reg   <= 11'd0;
                    end else if (cnt_reg == IP_HDR_LEN - 11'd1) begin
                        state_reg <= UDP_HDR;
                        cnt_reg   <= 11'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 11'd1;
                    end
                end

                UDP_HDR: begin
                    if (!rxdv_reg) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 11'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 11'd1;
                        case (cnt_reg)
                            11'd2:   port_reg[15:8] <= rxd_reg;
                            11'd3:   port_reg[7:0]  <= rxd_reg;
                            11'd4:   len_reg[15:8]  <= rxd_reg;
                            11'd5:   len_reg[7:0]   <= rxd_reg;
                            default: ;
                        endcase
                        if (cnt_reg == UDP_HDR_LEN - 11'd1) begin
                            cnt_reg <= 11'd0;
                            if (port_reg != LOCAL_PORT || !udp_len_ok) begin
                                state_reg <= DROP;
                            end else begin
                                payload_len_reg <= len_reg - 16'd8;
                                state_reg <= (len_reg == 16'd8) ? TAIL : PAYLOAD;
                            end
                        end
                    end
                end

                PAYLOAD: begin
                    if (!rxdv_reg) begin
                        // Truncated payload: the frame can never be good.
                        frame_err_reg <= 1'b1;
                        state_reg     <= IDLE;
                        cnt_reg       <= 11'd0;
                    end else begin
                        rx_valid_reg <= 1'b1;
                        rx_data_reg  <= rxd_reg;
                        rx_sof_reg   <= (cnt_reg == 11'd0);
                        if (pay_last) begin
                            rx_eof_reg <= 1'b1;
                            state_reg  <= TAIL;
                            cnt_reg    <= 11'd0;
                        end else begin
                            // Peek at the raw pin so a byte that is about to be
                            // the last one delivered still carries eof.
                            rx_eof_reg <= !e_rxdv;
                            cnt_reg    <= cnt_reg + 11'd1;
                        end
                    end
                end

                TAIL: begin
                    if (!rxdv_reg) begin
                        if (crc_reg == CRC_RESIDUE && !err_reg) begin
                            frame_ok_reg  <= 1'b1;
                            pkt_count_reg <= pkt_count_reg + 16'd1;
                        end else begin
                            frame_err_reg <= 1'b1;
                        end
                        state_reg <= IDLE;
                        cnt_reg   <= 11'd0;
                    end else begin
                        cnt_reg <= cnt_reg + 11'd1;
                    end
                end

                DROP: begin
                    if (!rxdv_reg) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 11'd0;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    cnt_reg   <= 11'd0;
                end
            endcase
        end
    end

    assign rx.rx_data     = rx_data_reg;
    assign rx.rx_valid    = rx_valid_reg;
    assign rx.rx_sof      = rx_sof_reg;
    assign rx.rx_eof      = rx_eof_reg;
    assign rx.payload_len = payload_len_reg;
    assign rx.frame_ok    = frame_ok_reg;
    assign rx.frame_err   = frame_err_reg;
    assign rx.pkt_count   = pkt_count_reg;

endmodule

// File: tb/tb_udp_cmd_rx.sv
// Scoreboard bench for udp_cmd_rx: frames are built with a locally computed
// FCS, expected payload bytes and frame results are queued as bytes are
// driven, and a negedge monitor pops and compares them as the DUT emits.
module tb_udp_cmd_rx;

    localparam logic [47:0] LOCAL_MAC  = 48'h00_0A_35_01_FE_C0;
    localparam logic [47:0] BCAST_MAC  = 48'hFF_FF_FF_FF_FF_FF;
    localparam logic [31:0] LOCAL_IP   = 32'hC0A8_0002;
    localparam logic [15:0] LOCAL_PORT = 16'd8080;
    localparam int          PAY_START  = 50;   // 8 preamble + 14 eth + 20 ip + 8 udp

    logic       e_rxc = 1'b0;
    logic       rst;
    logic       e_rxdv;
    logic       e_rxer;
    logic [7:0] e_rxd;

    udp_cmd_rx_if rx_if ();

    udp_cmd_rx dut (
        .e_rxc  (e_rxc),
        .rst    (rst),
        .e_rxdv (e_rxdv),
        .e_rxer (e_rxer),
        .e_rxd  (e_rxd),
        .rx     (rx_if)
    );

    always #4 e_rxc = ~e_rxc;

    int cyc = 0;
    always @(posedge e_rxc) cyc++;

    typedef struct {
        logic [7:0] d;
        logic       sof;
        logic       eof;
        int         cyc;
    } exp_byte_t;

    typedef struct {
        logic ok;
        int   cyc;
    } exp_res_t;

    exp_byte_t  byte_q[$];
    exp_res_t   res_q[$];
    logic [7:0] frm_q[$];
    logic [7:0] pay_q[$];

    int n_cmp   = 0;
    int n_bad   = 0;
    int exp_pkt = 0;

    exp_byte_t eb;
    exp_res_t  er;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            r = (r[0] ^ d[b]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    task automatic push16(input logic [15:0] v);
        frm_q.push_back(v[15:8]);
        frm_q.push_back(v[7:0]);
    endtask

    task automatic push32(input logic [31:0] v);
        push16(v[31:16]);
        push16(v[15:0]);
    endtask

    // Builds preamble, headers, pay_q, padding and FCS into frm_q.
    task automatic build_frame(input logic [47:0] mac, input logic [15:0] etype,
                               input logic [31:0] dip, input logic [15:0] dport, input int npad);
        logic [31:0] crc;
        logic [15:0] ulen;
        frm_q.delete();
        ulen = 16'(pay_q.size() + 8);
        repeat (7) frm_q.push_back(8'h55);
        frm_q.push_back(8'hD5);
        for (int k = 5; k >= 0; k--) frm_q.push_back(mac[8*k +: 8]);
        for (int k = 0; k < 6; k++) frm_q.push_back(8'h10 + 8'(k));
        push16(etype);
        frm_q.push_back(8'h45);
        frm_q.push_back(8'h00);
        push16(ulen + 16'd20);
        push16(16'h1234);
        push16(16'h4000);
        frm_q.push_back(8'h40);
        frm_q.push_back(8'h11);
        push16(16'h0000);
        push32(32'hC0A8_0001);
        push32(dip);
        push16(16'd5000);
        push16(dport);
        push16(ulen);
        push16(16'h0000);
        foreach (pay_q[k]) frm_q.push_back(pay_q[k]);
        repeat (npad) frm_q.push_back(8'h00);
        crc = 32'hFFFFFFFF;
        for (int k = 8; k < frm_q.size(); k++) crc = crc_upd(crc, frm_q[k]);
        crc = ~crc;
        for (int k = 0; k < 4; k++) frm_q.push_back(crc[8*k +: 8]);
    endtask

    task automatic drive_byte(input logic [7:0] b);
        @(posedge e_rxc);
        #1;
        e_rxdv = 1'b1;
        e_rxer = 1'b0;
        e_rxd  = b;
    endtask

    task automatic drive_idle(input int n);
        repeat (n) begin
            @(posedge e_rxc);
            #1;
            e_rxdv = 1'b0;
            e_rxd  = 8'h00;
        end
    endtask

    // Drives the first `total` bytes of frm_q, then one idle cycle. When the
    // frame is expected to be delivered, its payload bytes and final result
    // are queued with the cycle at which they must appear.
    task automatic send_frame(input string name, input int total, input logic deliver, input logic exp_ok);
        int plen;
        int last;
        plen = pay_q.size();
        last = PAY_START + plen;
        if (total < last) last = total;
        last = last - 1;
        for (int i = 0; i < total; i++) begin
            drive_byte(frm_q[i]);
            if (deliver && i >= PAY_START && i <= last) begin
                byte_q.push_back(exp_byte_t'{d: frm_q[i], sof: (i == PAY_START),
                                             eof: (i == last), cyc: cyc + 2});
            end
        end
        @(posedge e_rxc);
        #1;
        e_rxdv = 1'b0;
        e_rxd  = 8'h00;
        if (deliver) begin
            res_q.push_back(exp_res_t'{ok: exp_ok, cyc: cyc + 2});
        end
        $display("frame %s: %0d bytes driven, deliver=%0b ok=%0b", name, total, deliver, exp_ok);
    endtask

    task automatic end_checks(input string tag);
        drive_idle(4);
        check_eq({tag, "_bytes_left"}, 32'(byte_q.size()), 32'd0);
        check_eq({tag, "_results_left"}, 32'(res_q.size()), 32'd0);
        check_eq({tag, "_pkt_count"}, 32'(rx_if.pkt_count), 32'(exp_pkt));
    endtask

    // Monitor: every emitted byte and every status pulse must match the queue head.
    always @(negedge e_rxc) begin
        if (rx_if.rx_valid === 1'b1) begin
            check_eq("byte_expected", 32'(byte_q.size() > 0), 32'd1);
            if (byte_q.size() > 0) begin
                eb = byte_q.pop_front();
                check_eq("byte_data_sof_eof", 32'({rx_if.rx_data, rx_if.rx_sof, rx_if.rx_eof}),
                         32'({eb.d, eb.sof, eb.eof}));
                check_eq("byte_cycle", 32'(cyc), 32'(eb.cyc));
            end
        end
        if (rx_if.frame_ok === 1'b1 || rx_if.frame_err === 1'b1) begin
            check_eq("result_expected", 32'(res_q.size() > 0), 32'd1);
            if (res_q.size() > 0) begin
                er = res_q.pop_front();
                check_eq("result_ok_err", 32'({rx_if.frame_ok, rx_if.frame_err}), 32'({er.ok, ~er.ok}));
                check_eq("result_cycle", 32'(cyc), 32'(er.cyc));
            end
        end
    end

    initial begin
        rst    = 1'b1;
        e_rxdv = 1'b0;
        e_rxer = 1'b0;
        e_rxd  = 8'h00;
        repeat (3) @(posedge e_rxc);
        @(negedge e_rxc);
        check_eq("reset_rx_valid", 32'(rx_if.rx_valid), 32'd0);
        check_eq("reset_rx_data", 32'(rx_if.rx_data), 32'd0);
        check_eq("reset_frame_pulses", 32'({rx_if.frame_ok, rx_if.frame_err}), 32'd0);
        check_eq("reset_pkt_count", 32'(rx_if.pkt_count), 32'd0);
        check_eq("reset_payload_len", 32'(rx_if.payload_len), 32'd0);
        rst = 1'b0;
        drive_idle(2);

        // 1: good frame, 4-byte payload
        pay_q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 0);
        send_frame("t1_good", frm_q.size(), 1'b1, 1'b1);
        exp_pkt++;
        end_checks("t1");
        check_eq("t1_payload_len", 32'(rx_if.payload_len), 32'd4);

        // 2: same frame with one payload bit flipped after the FCS was computed
        frm_q[PAY_START] = frm_q[PAY_START] ^ 8'h01;
        send_frame("t2_bad_fcs", frm_q.size(), 1'b1, 1'b0);
        end_checks("t2");

        // 3: filtered frames produce nothing
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, 16'd8081, 0);
        send_frame("t3_port", frm_q.size(), 1'b0, 1'b0);
        drive_idle(1);
        build_frame(LOCAL_MAC, 16'h0806, LOCAL_IP, LOCAL_PORT, 0);
        send_frame("t3_ethertype", frm_q.size(), 1'b0, 1'b0);
        drive_idle(1);
        build_frame(LOCAL_MAC, 16'h0800, 32'hC0A8_0003, LOCAL_PORT, 0);
        send_frame("t3_dest_ip", frm_q.size(), 1'b0, 1'b0);
        end_checks("t3");

        // 4: broadcast, 1-byte payload padded to minimum frame size
        pay_q = '{8'h5A};
        build_frame(BCAST_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 17);
        send_frame("t4_bcast_pad", frm_q.size(), 1'b1, 1'b1);
        exp_pkt++;
        end_checks("t4");
        check_eq("t4_payload_len", 32'(rx_if.payload_len), 32'd1);

        // 5: payload truncated after 2 of 10 bytes, then a good frame after one idle cycle
        pay_q.delete();
        for (int k = 0; k < 10; k++) pay_q.push_back(8'h30 + 8'(k));
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 0);
        send_frame("t5_truncated", PAY_START + 2, 1'b1, 1'b0);
        send_frame("t5_follow", frm_q.size(), 1'b1, 1'b1);
        exp_pkt++;
        end_checks("t5");

        // 6: reset pulse in the middle of the payload
        pay_q.delete();
        for (int k = 0; k < 10; k++) pay_q.push_back(8'h10 + 8'(k));
        build_frame(LOCAL_MAC, 16'h0800, LOCAL_IP, LOCAL_PORT, 0);
        for (int i = 0; i <= PAY_START + 2; i++) begin
            drive_byte(frm_q[i]);
            if (i == PAY_START || i == PAY_START + 1) begin
                byte_q.push_back(exp_byte_t'{d: frm_q[i], sof: (i == PAY_START), eof: 1'b0, cyc: cyc + 2});
            end
        end
        @(posedge e_rxc);
        #1;
        rst   = 1'b1;
        e_rxd = frm_q[PAY_START + 3];
        @(posedge e_rxc);
        #1;
        rst   = 1'b0;
        e_rxd = frm_q[PAY_START + 4];
        exp_pkt = 0;
        @(negedge e_rxc);
        check_eq("t6_rst_rx_valid", 32'(rx_if.rx_valid), 32'd0);
        check_eq("t6_rst_pulses", 32'({rx_if.frame_ok, rx_if.frame_err}), 32'd0);
        check_eq("t6_rst_pkt_count", 32'(rx_if.pkt_count), 32'(exp_pkt));
        check_eq("t6_rst_payload_len", 32'(rx_if.payload_len), 32'd0);
        check_eq("t6_rst_rx_data", 32'(rx_if.rx_data), 32'd0);
        for (int i = PAY_START + 5; i < frm_q.size(); i++) drive_byte(frm_q[i]);
        drive_idle(3);
        $display("frame t6_reset_mid_payload: aborted by reset");
        send_frame("t6_after_reset", frm_q.size(), 1'b1, 1'b1);
        exp_pkt++;
        end_checks("t6");
        check_eq("t6_payload_len", 32'(rx_if.payload_len), 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
